// File: rtl/chunk_capture_buffer_pkg.sv
// Shared definitions for the chunk capture buffer and its downstream processor.
// Holds the capture FSM encoding and the default sample/chunk dimensions.
package chunk_capture_buffer_pkg;

  localparam int DEF_SAMPLE_SIZE  = 24;
  localparam int DEF_IO_BUFF_SIZE = 64;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_FILL = 1'b1
  } cap_state_e;

endpackage

// File: rtl/chunk_capture_buffer_bank_ram.sv
// One chunk bank: single synchronous write port, combinational read port.
// Contents are intentionally not reset.
module chunk_capture_buffer_bank_ram
  import chunk_capture_buffer_pkg::*;
#(
  parameter int WIDTH     = DEF_SAMPLE_SIZE,
  parameter int DEPTH     = DEF_IO_BUFF_SIZE,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chunk_capture_buffer.sv
// Ping-pong capture of a sample stream into two chunk banks; pulses when a bank completes.
// Optional sticky overrun detection is built when CHUNK_OVERRUN_DETECT_EN is defined.
//
// state    | meaning
// CAP_IDLE | capture disabled, write pointer parked at 0
// CAP_FILL | writing valid samples into the current write bank
module chunk_capture_buffer
  import chunk_capture_buffer_pkg::*;
#(
  parameter int SAMPLE_SIZE      = DEF_SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = DEF_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [SAMPLE_SIZE-1:0]      in_sample,
  output logic                        chunk_pulse,
  input  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
  output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
  output logic                        wr_bank_o,
  output logic [IO_BUFF_PTR_BITS-1:0] fill_level
`ifdef CHUNK_OVERRUN_DETECT_EN
  ,
  input  logic                        proc_busy,
  output logic                        overrun
`endif
);

  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_SLOT = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  cap_state_e                  state, state_nxt;
  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr;
  logic                        wr_bank, rd_bank;
  logic                        wr_en, swap;
  logic [SAMPLE_SIZE-1:0]      rd_data0, rd_data1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CAP_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAP_IDLE: if (en)  state_nxt = CAP_FILL;
      CAP_FILL: if (!en) state_nxt = CAP_IDLE;
      default:           state_nxt = CAP_IDLE;
    endcase
  end

  always_comb begin
    wr_en = (state == CAP_FILL) && en && in_valid;
    swap  = wr_en && (wr_ptr == LAST_SLOT);
  end

  // Swap and pointer wrap share one edge so the read bank holds the new chunk during the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      chunk_pulse <= 1'b0;
    end else begin
      chunk_pulse <= swap;
      if ((state == CAP_FILL) && !en) begin
        wr_ptr <= '0;
      end else if (swap) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  chunk_capture_buffer_bank_ram #(
    .WIDTH(SAMPLE_SIZE), .DEPTH(IO_BUFF_SIZE), .ADDR_BITS(IO_BUFF_PTR_BITS)
  ) u_bank0 (
    .clk(clk), .we(wr_en && !wr_bank), .waddr(wr_ptr), .wdata(in_sample),
    .raddr(input_buff_ptr), .rdata(rd_data0)
  );

  chunk_capture_buffer_bank_ram #(
    .WIDTH(SAMPLE_SIZE), .DEPTH(IO_BUFF_SIZE), .ADDR_BITS(IO_BUFF_PTR_BITS)
  ) u_bank1 (
    .clk(clk), .we(wr_en && wr_bank), .waddr(wr_ptr), .wdata(in_sample),
    .raddr(input_buff_ptr), .rdata(rd_data1)
  );

  assign input_buff_sample = rd_bank ? rd_data1 : rd_data0;
  assign wr_bank_o         = wr_bank;
  assign fill_level        = wr_ptr;

`ifdef CHUNK_OVERRUN_DETECT_EN
  logic en_q;

  // Sticky until reset or a falling edge of en; the swap itself is never blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      en_q <= en;
      if (en_q && !en)            overrun <= 1'b0;
      else if (swap && proc_busy) overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_chunk_capture_buffer.sv
// Scoreboard bench for chunk_capture_buffer: driven samples are queued per chunk and
// popped into a read-bank model when chunk_pulse appears.
module tb_chunk_capture_buffer;

  localparam int SS = 24;
  localparam int BS = 64;
  localparam int PB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [SS-1:0] in_sample;
  logic          chunk_pulse;
  logic [PB-1:0] input_buff_ptr;
  logic [SS-1:0] input_buff_sample;
  logic          wr_bank_o;
  logic [PB-1:0] fill_level;
  logic          proc_busy;
`ifdef CHUNK_OVERRUN_DETECT_EN
  logic          overrun;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [SS-1:0] pend_q[$];
  logic [SS-1:0] exp_q[$];
  logic [SS-1:0] rd_model [BS];
  bit            rd_valid = 0;
  bit            m_fill = 0;
  bit            m_bank = 0;
  bit            m_en_q = 0;
  bit            m_ovr  = 0;

  chunk_capture_buffer #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(BS), .IO_BUFF_PTR_BITS(PB)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in_valid(in_valid),
    .in_sample(in_sample),
    .chunk_pulse(chunk_pulse),
    .input_buff_ptr(input_buff_ptr),
    .input_buff_sample(input_buff_sample),
    .wr_bank_o(wr_bank_o),
    .fill_level(fill_level)
`ifdef CHUNK_OVERRUN_DETECT_EN
    ,
    .proc_busy(proc_busy),
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Model the upcoming edge from the inputs now driven, then check just after it.
  task automatic step();
    bit pulse_exp;
    pulse_exp = 0;
    if (rst) begin
      if (m_en_q && !en) m_ovr = 0;
      if (!m_fill) begin
        if (en) m_fill = 1;
      end else if (!en) begin
        m_fill = 0;
        pend_q.delete();
      end else if (in_valid) begin
        pend_q.push_back(in_sample);
        if (pend_q.size() == BS) begin
          while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
          pulse_exp = 1;
          m_bank    = !m_bank;
          if (proc_busy) m_ovr = 1;
        end
      end
      m_en_q = en;
    end
    @(posedge clk);
    #1;
    chk("chunk_pulse", 32'(chunk_pulse), 32'(pulse_exp));
    chk("fill_level", 32'(fill_level), 32'(pend_q.size()));
    chk("wr_bank_o", 32'(wr_bank_o), 32'(m_bank));
`ifdef CHUNK_OVERRUN_DETECT_EN
    chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
    if (chunk_pulse) begin
      pulses++;
      if (exp_q.size() >= BS) begin
        for (int i = 0; i < BS; i++) rd_model[i] = exp_q.pop_front();
        rd_valid = 1;
      end
    end
  endtask

  task automatic rd_chk(input int p);
    input_buff_ptr = PB'(p);
    #1;
    if (rd_valid) chk("rd_sample", 32'(input_buff_sample), 32'(rd_model[p]));
  endtask

  task automatic send(input int val);
    in_valid  = 1'b1;
    in_sample = SS'(val);
    step();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_sample = '0;
    input_buff_ptr = '0; proc_busy = 1'b0;

    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    en = 1'b1;
    step();

    // first chunk, back-to-back 0..63
    for (int i = 0; i < BS; i++) send(i);
    chk("pulse_count_1", 32'(pulses), 32'd1);
    input_buff_ptr = 6'd0;  #1; chk("rd_ptr0", 32'(input_buff_sample), 32'd0);
    input_buff_ptr = 6'd5;  #1; chk("rd_ptr5", 32'(input_buff_sample), 32'd5);
    input_buff_ptr = 6'd63; #1; chk("rd_ptr63", 32'(input_buff_sample), 32'd63);

    // second chunk, one sample every 4th cycle, reading the first chunk meanwhile
    proc_busy = 1'b1;
    for (int i = 0; i < BS; i++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid  = (k == 0);
        in_sample = SS'(100 + i);
        step();
        if (pulses == 1) rd_chk(int'($urandom_range(0, BS - 1)));
      end
    end
    chk("pulse_count_2", 32'(pulses), 32'd2);
    input_buff_ptr = 6'd0; #1; chk("rd_new_chunk", 32'(input_buff_sample), 32'd100);
    rd_chk(63);
    proc_busy = 1'b0;
    in_valid  = 1'b0;
    step();

    // partial chunk discarded on en drop
    for (int i = 0; i < 10; i++) send(200 + i);
    en = 1'b0; in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_sample = SS'(777);
    step();
    step();
    en = 1'b1; in_sample = SS'(999);
    step();
    for (int i = 0; i < BS; i++) send(300 + i);
    in_valid = 1'b0;
    chk("pulse_count_3", 32'(pulses), 32'd3);
    input_buff_ptr = 6'd0; #1; chk("rd_after_discard", 32'(input_buff_sample), 32'd300);
    rd_chk(9);
    rd_chk(63);
    step();

    // asynchronous reset mid-chunk
    for (int i = 0; i < 30; i++) send(400 + i);
    in_valid = 1'b0;
    chk("fill_before_rst", 32'(fill_level), 32'd30);
    #2;
    rst = 1'b0;
    #1;
    chk("async_pulse", 32'(chunk_pulse), 32'd0);
    chk("async_fill", 32'(fill_level), 32'd0);
    chk("async_bank", 32'(wr_bank_o), 32'd0);
`ifdef CHUNK_OVERRUN_DETECT_EN
    chk("async_overrun", 32'(overrun), 32'd0);
`endif
    m_fill = 0; m_bank = 0; m_en_q = 0; m_ovr = 0; rd_valid = 0;
    pend_q.delete();
    exp_q.delete();
    step();
    step();
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) send(500 + i);
    in_valid = 1'b0;
    step();
    chk("pulse_count_final", 32'(pulses), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
